unit_scheduler: RTL and testbench
=================================

# unit_scheduler

Round-robin scheduler that shares the single 8-bit operand bus (`r0`) and 2-bit `check` field between the co-processor (requester 0) and the fault processor (requester 1). It sits between the top-level pins and the two units. It grants one unit at a time, latches its operand for the grant duration, and bounds every grant with a timeout. A fault lockout halts all grants after repeated faults until software clears it.

## Interface
- `HOLD_CYCLES`, default 4: maximum grant length in cycles, legal range 1..15.
- `FAULT_LIMIT`, default 3: fault count that triggers lockout, legal range 1..3.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low; one clock, reset is synchronous and active-low.
- `req` in 2: `req[0]` is the co_processor request, `req[1]` is the fault_pro request; level-sensitive.
- `r0` in 8: operand from the input pins.
- `check` in 2: mode field from the pins; `2'b11` is also the lockout-clear command.
- `done` in 2: per-unit completion pulse; only valid while that unit is granted.
- `fault` in 1: fault pulse from fault_pro.
- `gnt` out 2: grant, one-hot or zero.
- `r0_out` out 8: operand latched at grant, routed to the granted unit.
- `check_out` out 2: `check` latched at grant.
- `busy` out 1: high while any grant is active.
- `timeout` out 1: one-cycle pulse when a grant expires without `done`.
- `lockout` out 1: high in LOCK.
- `fault_cnt` out 2: saturating fault count.

## Operation
- Reset (`reset`=0 at a clock edge): state IDLE, priority pointer selects unit 0. All outputs are 0: `gnt`, `r0_out`, `check_out`, `busy`, `timeout`, `lockout`, `fault_cnt`, and the hold counter.
- States: IDLE, GNT0, GNT1, LOCK. All outputs are registered.
- IDLE:
  - If `req` is nonzero, grant per the pointer. Only `req[0]` set → GNT0. Only `req[1]` set → GNT1. Both set → the unit the pointer selects.
  - On the same edge: latch `r0` into `r0_out` and `check` into `check_out`, clear the hold counter, and set the pointer to the other unit.
- GNTx: `gnt[x]`=1 and `busy`=1. `r0_out`/`check_out` stay frozen regardless of pin changes. The hold counter increments each cycle.
  - `done[x]`=1 → IDLE.
  - Hold counter reaches `HOLD_CYCLES` without `done[x]` → IDLE and pulse `timeout`.
  - `done` of the non-granted unit is ignored.
  - Dropping `req[x]` does not end the grant early.
- Leaving a grant state always passes through IDLE for at least one cycle (turnaround). `r0_out`/`check_out` clear to 0 on entry to IDLE.
- Faults:
  - Each cycle with `fault`=1 outside LOCK increments `fault_cnt`, saturating at `FAULT_LIMIT`.
  - When `fault_cnt` reaches `FAULT_LIMIT`, the next state is LOCK from any state. This overrides `done` and timeout, drops any grant, and produces no `timeout` pulse.
- LOCK: `lockout`=1, `gnt`=0, `busy`=0, requests ignored, `fault` ignored. `check`==`2'b11` sampled → IDLE, with `fault_cnt` cleared to 0 and `lockout` cleared on the same edge.
- Simultaneous `done[x]` and `fault`: the grant ends normally and the fault is counted. If the count hits the limit, LOCK wins.
- Reset asserted mid-grant or in LOCK: immediate return to the reset state on that edge; no `timeout` pulse.

## Timing
- Latency from request to grant: `req` sampled high at edge N in IDLE → `gnt` high after edge N, so it is visible during cycle N+1.
- Grant length with `done`: `done[x]` sampled at edge M → `gnt` low after M. The earliest next grant is after M+1.
- Grant length without `done`: `gnt` stays high for exactly `HOLD_CYCLES` cycles. `timeout` is high during the first IDLE cycle.
- Fault to lockout: the fault that reaches the limit, sampled at edge F → `fault_cnt`=`FAULT_LIMIT` and `lockout`=1 both after edge F; `gnt` is 0 after F.
- Lockout clear: `check`=`2'b11` sampled at edge C → `lockout`=0 after C. A pending `req` is granted after C+1.
- Throughput: with both requesters continuously active, the grants alternate 0,1,0,1 with one IDLE cycle between them.

## Test plan
- Reset, then `req`=`2'b01`, `r0`=`8'hA5`, `check`=`2'b01`; change `r0` to `8'h00` during the grant; `done[0]` on the 2nd grant cycle.
  - Required: `gnt`=`01` for 2 cycles, `r0_out`=`A5` throughout, `busy`=1 during the grant, then IDLE with `r0_out`=0.
- `req`=`2'b11` held continuously, `done` pulsed on every 1st grant cycle.
  - Required: grant sequence 01, 00, 10, 00, 01; the first grant after reset goes to unit 0.
- `req`=`2'b10`, no `done`, `HOLD_CYCLES`=4.
  - Required: `gnt`=`10` for exactly 4 cycles, then a one-cycle `timeout` pulse in IDLE.
- Three `fault` pulses, the 3rd during GNT1, `FAULT_LIMIT`=3.
  - Required: `fault_cnt` steps 1, 2, 3; `lockout`=1 and `gnt`=0 the cycle after the 3rd pulse; no `timeout`.
  - Then `req`=`11`: no grant. Then `check`=`2'b11`: `lockout`=0, `fault_cnt`=0, and a grant follows.
- `done[1]` and `fault` in the same cycle with `fault_cnt`=1.
  - Required: the grant ends, `fault_cnt`=2, no lockout.
- Assert `reset`=0 during GNT0 on its 2nd cycle.
  - Required: after that edge all outputs are 0, with no `timeout` pulse.

Source files
------------

// File: rtl/unit_scheduler_if.sv
// Pin-side bundle for the scheduler that shares the r0 operand bus and check
// field between the co-processor (unit 0) and the fault processor (unit 1).
// The pins or a testbench drive through master; the scheduler uses slave.
interface unit_scheduler_if;
  logic [1:0] req;
  logic [7:0] r0;
  logic [1:0] check;
  logic [1:0] done;
  logic       fault;
  logic [1:0] gnt;
  logic [7:0] r0_out;
  logic [1:0] check_out;
  logic       busy;
  logic       timeout;
  logic       lockout;
  logic [1:0] fault_cnt;

  modport master (
    output req, r0, check, done, fault,
    input  gnt, r0_out, check_out, busy, timeout, lockout, fault_cnt
  );

  modport slave (
    input  req, r0, check, done, fault,
    output gnt, r0_out, check_out, busy, timeout, lockout, fault_cnt
  );
endinterface

// File: rtl/unit_scheduler.sv
// Round-robin scheduler for the shared r0/check bus. It grants one unit at a
// time and freezes that unit's operand for the whole grant. Every grant is
// bounded by HOLD_CYCLES. Repeated faults force a lockout, and only a
// check == 2'b11 command releases it.
module unit_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int FAULT_LIMIT = 3
) (
  input logic              clk,
  input logic              reset,
  unit_scheduler_if.slave  bus
);

  localparam logic [1:0] LIMIT     = 2'(FAULT_LIMIT);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, LOCK} state_t;

  state_t     state_q;
  logic       ptr_q;
  logic [3:0] holdCnt_q;
  logic [1:0] gnt_q;
  logic [7:0] r0Out_q;
  logic [1:0] checkOut_q;
  logic       busy_q;
  logic       timeout_q;
  logic       lockout_q;
  logic [1:0] faultCnt_q;

  logic [1:0] faultCnt_d;
  logic       lockHit;
  logic       grantedUnit;

  // Saturating fault count; faults are not counted while locked out
  always_comb begin
    faultCnt_d = faultCnt_q;
    if ((state_q != LOCK) && bus.fault && (faultCnt_q < LIMIT)) begin
      faultCnt_d = faultCnt_q + 2'd1;
    end
  end

  assign lockHit     = (state_q != LOCK) && (faultCnt_d >= LIMIT);
  assign grantedUnit = (state_q == GNT1);

  // Grant FSM with registered outputs; reaching the fault limit overrides everything else
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      holdCnt_q  <= 4'd0;
      gnt_q      <= 2'b00;
      r0Out_q    <= 8'h00;
      checkOut_q <= 2'b00;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      lockout_q  <= 1'b0;
      faultCnt_q <= 2'b00;
    end else begin
      timeout_q  <= 1'b0;
      faultCnt_q <= faultCnt_d;
      if (lockHit) begin
        state_q    <= LOCK;
        gnt_q      <= 2'b00;
        busy_q     <= 1'b0;
        lockout_q  <= 1'b1;
        r0Out_q    <= 8'h00;
        checkOut_q <= 2'b00;
        holdCnt_q  <= 4'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.req != 2'b00) begin
              if (bus.req[0] && (!bus.req[1] || !ptr_q)) begin
                state_q <= GNT0;
                gnt_q   <= 2'b01;
                ptr_q   <= 1'b1;
              end else begin
                state_q <= GNT1;
                gnt_q   <= 2'b10;
                ptr_q   <= 1'b0;
              end
              busy_q     <= 1'b1;
              r0Out_q    <= bus.r0;
              checkOut_q <= bus.check;
              holdCnt_q  <= 4'd0;
            end
          end
          GNT0, GNT1: begin
            if (bus.done[grantedUnit] || (holdCnt_q == HOLD_LAST)) begin
              state_q    <= IDLE;
              gnt_q      <= 2'b00;
              busy_q     <= 1'b0;
              r0Out_q    <= 8'h00;
              checkOut_q <= 2'b00;
              timeout_q  <= !bus.done[grantedUnit];
            end else begin
              holdCnt_q <= holdCnt_q + 4'd1;
            end
          end
          LOCK: begin
            if (bus.check == 2'b11) begin
              state_q    <= IDLE;
              lockout_q  <= 1'b0;
              faultCnt_q <= 2'b00;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.r0_out    = r0Out_q;
  assign bus.check_out = checkOut_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;
  assign bus.lockout   = lockout_q;
  assign bus.fault_cnt = faultCnt_q;

endmodule

// File: tb/tb_unit_scheduler.sv
// Directed scoreboard bench for unit_scheduler with default parameters
// (HOLD_CYCLES = 4, FAULT_LIMIT = 3). Each stimulus cycle queues the output
// vector expected after the next rising edge. A separate monitor pops the
// queue and compares 1 time unit after every rising edge.
module tb_unit_scheduler;

  logic clk;
  logic reset;

  unit_scheduler_if bus();

  unit_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [16:0] exp;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one popped expectation against the live DUT outputs
  task automatic checkOutput(input exp_t e);
    logic [16:0] act;
    act = {bus.gnt, bus.r0_out, bus.check_out, bus.busy, bus.timeout,
           bus.lockout, bus.fault_cnt};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: actual gnt=%b r0_out=%h check_out=%b busy=%b timeout=%b lockout=%b fault_cnt=%0d, required gnt=%b r0_out=%h check_out=%b busy=%b timeout=%b lockout=%b fault_cnt=%0d",
               e.name, act[16:15], act[14:7], act[6:5], act[4], act[3], act[2], act[1:0],
               e.exp[16:15], e.exp[14:7], e.exp[6:5], e.exp[4], e.exp[3], e.exp[2], e.exp[1:0]);
    end
  endtask

  // Monitor: sample just after each rising edge and check against the scoreboard
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the expected outputs
  task automatic applyStimulus(
    input string      name,
    input logic       rst,
    input logic [1:0] req,
    input logic [7:0] r0,
    input logic [1:0] chk,
    input logic [1:0] dn,
    input logic       flt,
    input logic [1:0] eGnt,
    input logic [7:0] eR0,
    input logic [1:0] eChk,
    input logic       eBusy,
    input logic       eTo,
    input logic       eLock,
    input logic [1:0] eCnt
  );
    exp_t e;
    reset     = rst;
    bus.req   = req;
    bus.r0    = r0;
    bus.check = chk;
    bus.done  = dn;
    bus.fault = flt;
    e.name = name;
    e.exp  = {eGnt, eR0, eChk, eBusy, eTo, eLock, eCnt};
    expQ.push_back(e);
    @(negedge clk);
  endtask

  // Safety net in case the stimulus ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus table
  initial begin
    reset     = 1'b0;
    bus.req   = 2'b00;
    bus.r0    = 8'h00;
    bus.check = 2'b00;
    bus.done  = 2'b00;
    bus.fault = 1'b0;
    @(negedge clk);

    //             name            rst req    r0     chk    done   flt  gnt    r0_out chk_o busy to   lock cnt
    // Single grant to unit 0: operand frozen, done on the 2nd grant cycle
    applyStimulus("reset",         0, 2'b00, 8'h00, 2'b00, 2'b00, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);
    applyStimulus("grant0",        1, 2'b01, 8'hA5, 2'b01, 2'b00, 0, 2'b01, 8'hA5, 2'b01, 1, 0, 0, 2'd0);
    applyStimulus("grant0_frozen", 1, 2'b01, 8'h00, 2'b01, 2'b00, 0, 2'b01, 8'hA5, 2'b01, 1, 0, 0, 2'd0);
    applyStimulus("done0_idle",    1, 2'b00, 8'h00, 2'b01, 2'b01, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);
    applyStimulus("idle_quiet",    1, 2'b00, 8'h00, 2'b00, 2'b00, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);

    // Round robin with both units requesting; first grant after reset goes to unit 0
    applyStimulus("rr_reset",      0, 2'b11, 8'h00, 2'b00, 2'b00, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);
    applyStimulus("rr_g0",         1, 2'b11, 8'h11, 2'b10, 2'b00, 0, 2'b01, 8'h11, 2'b10, 1, 0, 0, 2'd0);
    applyStimulus("rr_idle1",      1, 2'b11, 8'h11, 2'b10, 2'b01, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);
    applyStimulus("rr_g1",         1, 2'b11, 8'h22, 2'b00, 2'b00, 0, 2'b10, 8'h22, 2'b00, 1, 0, 0, 2'd0);
    applyStimulus("rr_idle2",      1, 2'b11, 8'h22, 2'b00, 2'b10, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);
    applyStimulus("rr_g0_again",   1, 2'b11, 8'h33, 2'b01, 2'b00, 0, 2'b01, 8'h33, 2'b01, 1, 0, 0, 2'd0);
    applyStimulus("rr_idle3",      1, 2'b00, 8'h33, 2'b01, 2'b01, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);

    // Unit 1 grant without done: req dropped and foreign done ignored, 4-cycle timeout
    applyStimulus("to_g1_c1",      1, 2'b10, 8'h44, 2'b10, 2'b00, 0, 2'b10, 8'h44, 2'b10, 1, 0, 0, 2'd0);
    applyStimulus("to_g1_c2",      1, 2'b00, 8'hFF, 2'b00, 2'b01, 0, 2'b10, 8'h44, 2'b10, 1, 0, 0, 2'd0);
    applyStimulus("to_g1_c3",      1, 2'b00, 8'hFF, 2'b00, 2'b00, 0, 2'b10, 8'h44, 2'b10, 1, 0, 0, 2'd0);
    applyStimulus("to_g1_c4",      1, 2'b00, 8'hFF, 2'b00, 2'b00, 0, 2'b10, 8'h44, 2'b10, 1, 0, 0, 2'd0);
    applyStimulus("to_pulse",      1, 2'b00, 8'h00, 2'b00, 2'b00, 0, 2'b00, 8'h00, 2'b00, 0, 1, 0, 2'd0);
    applyStimulus("to_pulse_end",  1, 2'b00, 8'h00, 2'b00, 2'b00, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);

    // Fault lockout: third fault lands during a unit 1 grant
    applyStimulus("fault1",        1, 2'b00, 8'h00, 2'b00, 2'b00, 1, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd1);
    applyStimulus("fault2",        1, 2'b00, 8'h00, 2'b00, 2'b00, 1, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd2);
    applyStimulus("lk_g1",         1, 2'b10, 8'h55, 2'b01, 2'b00, 0, 2'b10, 8'h55, 2'b01, 1, 0, 0, 2'd2);
    applyStimulus("fault3_lock",   1, 2'b10, 8'h55, 2'b01, 2'b00, 1, 2'b00, 8'h00, 2'b00, 0, 0, 1, 2'd3);
    applyStimulus("lock_ignore",   1, 2'b11, 8'h55, 2'b00, 2'b00, 1, 2'b00, 8'h00, 2'b00, 0, 0, 1, 2'd3);
    applyStimulus("lock_hold",     1, 2'b11, 8'h55, 2'b01, 2'b00, 0, 2'b00, 8'h00, 2'b00, 0, 0, 1, 2'd3);
    applyStimulus("lock_clear",    1, 2'b11, 8'h55, 2'b11, 2'b00, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);
    applyStimulus("post_clear_g0", 1, 2'b11, 8'h66, 2'b00, 2'b00, 0, 2'b01, 8'h66, 2'b00, 1, 0, 0, 2'd0);
    applyStimulus("post_clear_id", 1, 2'b00, 8'h00, 2'b00, 2'b01, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);

    // done[1] together with a fault while fault_cnt is 1
    applyStimulus("df_fault1",     1, 2'b00, 8'h00, 2'b00, 2'b00, 1, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd1);
    applyStimulus("df_g1",         1, 2'b10, 8'h77, 2'b10, 2'b00, 0, 2'b10, 8'h77, 2'b10, 1, 0, 0, 2'd1);
    applyStimulus("df_done_fault", 1, 2'b00, 8'h77, 2'b10, 2'b10, 1, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd2);
    applyStimulus("df_idle",       1, 2'b00, 8'h00, 2'b00, 2'b00, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd2);

    // Reset in the middle of a unit 0 grant
    applyStimulus("mr_g0_c1",      1, 2'b01, 8'h88, 2'b11, 2'b00, 0, 2'b01, 8'h88, 2'b11, 1, 0, 0, 2'd2);
    applyStimulus("mr_g0_c2",      1, 2'b01, 8'h00, 2'b00, 2'b00, 0, 2'b01, 8'h88, 2'b11, 1, 0, 0, 2'd2);
    applyStimulus("mr_reset",      0, 2'b01, 8'h00, 2'b00, 2'b00, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);
    applyStimulus("mr_after",      1, 2'b00, 8'h00, 2'b00, 2'b00, 0, 2'b00, 8'h00, 2'b00, 0, 0, 0, 2'd0);

    // Every queued expectation must have been consumed by the monitor
    @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: actual %0d entries left, required 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
